// File: rtl/regfile_wb_arbiter_if.sv
// Regfile writeback bundle: pipeline writeback (A), multicycle-unit writeback stream (B),
// regfile write port and decode hazard lookups, grouped for the arbiter and its driver.
interface regfile_wb_arbiter_if;
  logic        a_we;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic        a_stall;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_wa;
  logic [31:0] b_wd;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        hazard1;
  logic        hazard2;

  modport slave (
    input  a_we, a_wa, a_wd, b_valid, b_wa, b_wd, ra1, ra2,
    output a_stall, b_ready, rf_we, rf_wa, rf_wd, hazard1, hazard2
  );

  modport master (
    output a_we, a_wa, a_wd, b_valid, b_wa, b_wd, ra1, ra2,
    input  a_stall, b_ready, rf_we, rf_wa, rf_wd, hazard1, hazard2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single regfile write port shared by pipeline writeback (A) and a FIFO-buffered B stream,
// with bounded-wait forced B grants and read-hazard scoreboard. Option: WB_ARB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input logic                clk,
  input logic                rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
`ifdef WB_ARB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic [4:0]    wa_q [DEPTH];
  logic [31:0]   wd_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;

  logic             nonempty_s, a_eff_s, b_hs_s, byp_s, enq_s;
  logic             grant_head_s, grant_a_s, stall_s;
  logic             a_hit_s, hit1_s, hit2_s;
  logic [DEPTH-1:0] vld_s;

  function automatic logic entry_valid(input logic [PW-1:0] idx, input logic [PW-1:0] rd,
                                       input logic [CW-1:0] cnt);
    logic [PW-1:0] off;
    off = idx - rd;
    return CW'(off) < cnt;
  endfunction

  assign nonempty_s  = (count_q != {CW{1'b0}});
  assign a_eff_s     = bus.a_we & (bus.a_wa != 5'd0);
  assign bus.b_ready = (count_q < CW'(DEPTH)) & ~rst;
  assign b_hs_s      = bus.b_valid & bus.b_ready;

  // Scoreboard match of A address and decode read addresses against queued entries
  always_comb begin
    a_hit_s = 1'b0;
    hit1_s  = 1'b0;
    hit2_s  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      vld_s[i] = entry_valid(PW'(i), rd_ptr_q, count_q);
      a_hit_s  = a_hit_s | (vld_s[i] & (wa_q[i] == bus.a_wa));
      hit1_s   = hit1_s  | (vld_s[i] & (wa_q[i] == bus.ra1));
      hit2_s   = hit2_s  | (vld_s[i] & (wa_q[i] == bus.ra2));
    end
  end

  assign bus.hazard1 = ~rst & (bus.ra1 != 5'd0) & hit1_s;
  assign bus.hazard2 = ~rst & (bus.ra2 != 5'd0) & hit2_s;

  // Arbitration priority: starvation guard, WAW ordering, A, FIFO drain, bypass
  always_comb begin
    grant_head_s = 1'b0;
    grant_a_s    = 1'b0;
    stall_s      = 1'b0;
    byp_s        = 1'b0;
    if (rst) begin
      grant_head_s = 1'b0;
    end else if (nonempty_s && (wait_q == WW'(MAX_WAIT))) begin
      grant_head_s = 1'b1;
      stall_s      = 1'b1;
    end else if (a_eff_s && a_hit_s) begin
      grant_head_s = 1'b1;
      stall_s      = 1'b1;
    end else if (a_eff_s) begin
      grant_a_s = 1'b1;
    end else if (nonempty_s) begin
      grant_head_s = 1'b1;
    end else begin
      byp_s = BYPASS & b_hs_s & (bus.b_wa != 5'd0);
    end
  end

  assign enq_s       = b_hs_s & (bus.b_wa != 5'd0) & ~byp_s;
  assign bus.a_stall = stall_s;

  // Write-port mux
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wa = 5'd0;
    bus.rf_wd = 32'd0;
    if (grant_head_s) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = wa_q[rd_ptr_q];
      bus.rf_wd = wd_q[rd_ptr_q];
    end else if (grant_a_s) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = bus.a_wa;
      bus.rf_wd = bus.a_wd;
    end else if (byp_s) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = bus.b_wa;
      bus.rf_wd = bus.b_wd;
    end else begin
      bus.rf_we = 1'b0;
    end
  end

  // FIFO pointer/count and head wait-counter next state
  always_comb begin
    wr_ptr_d = enq_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = grant_head_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({enq_s, grant_head_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (!nonempty_s || grant_head_s) begin
      wait_d = {WW{1'b0}};
    end else if (grant_a_s && (wait_q != WW'(MAX_WAIT))) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      wait_q   <= {WW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
    end
  end

  // Entry storage; contents are qualified by pointers/count so need no reset
  always_ff @(posedge clk) begin
    if (enq_s) begin
      wa_q[wr_ptr_q] <= bus.b_wa;
      wd_q[wr_ptr_q] <= bus.b_wd;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter; expectations follow WB_ARB_BYPASS_EN when defined.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  regfile_wb_arbiter_if ifc ();

  regfile_wb_arbiter #(.DEPTH(4), .MAX_WAIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ifc.a_we = 1'b0; ifc.a_wa = 5'd0; ifc.a_wd = 32'd0;
    ifc.b_valid = 1'b0; ifc.b_wa = 5'd0; ifc.b_wd = 32'd0;
    ifc.ra1 = 5'd0; ifc.ra2 = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    ifc.a_we = 1'b1; ifc.a_wa = 5'd5; ifc.b_valid = 1'b1; ifc.b_wa = 5'd6; ifc.ra1 = 5'd6;
    #1;
    vectors++;
    if (ifc.rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got=%0h exp=0", ifc.rf_we); end
    vectors++;
    if (ifc.a_stall !== 1'b0) begin errors++; $display("FAIL rst_a_stall got=%0h exp=0", ifc.a_stall); end
    vectors++;
    if (ifc.b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready got=%0h exp=0", ifc.b_ready); end
    vectors++;
    if (ifc.hazard1 !== 1'b0) begin errors++; $display("FAIL rst_hazard1 got=%0h exp=0", ifc.hazard1); end
    tick();
    rst = 1'b0;
    idle();
    #1;
    vectors++;
    if (ifc.b_ready !== 1'b1) begin errors++; $display("FAIL rel_b_ready got=%0h exp=1", ifc.b_ready); end
    vectors++;
    if (ifc.rf_we !== 1'b0) begin errors++; $display("FAIL rel_rf_we got=%0h exp=0", ifc.rf_we); end
    tick();
  endtask

  task automatic test_a_write();
    idle();
    ifc.a_we = 1'b1; ifc.a_wa = 5'd5; ifc.a_wd = 32'h0000_1234;
    #1;
    vectors++;
    if (ifc.rf_we !== 1'b1) begin errors++; $display("FAIL a_rf_we got=%0h exp=1", ifc.rf_we); end
    vectors++;
    if (ifc.rf_wa !== 5'd5) begin errors++; $display("FAIL a_rf_wa got=%0d exp=5", ifc.rf_wa); end
    vectors++;
    if (ifc.rf_wd !== 32'h0000_1234) begin errors++; $display("FAIL a_rf_wd got=%0h exp=1234", ifc.rf_wd); end
    vectors++;
    if (ifc.a_stall !== 1'b0) begin errors++; $display("FAIL a_stall got=%0h exp=0", ifc.a_stall); end
    tick();
  endtask

  task automatic test_b_drain();
    logic byp;
`ifdef WB_ARB_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    idle();
    ifc.b_valid = 1'b1; ifc.b_wa = 5'd8; ifc.b_wd = 32'h0000_00AA; ifc.ra1 = 5'd8;
    #1;
    vectors++;
    if (ifc.rf_we !== byp) begin errors++; $display("FAIL b0_rf_we got=%0h exp=%0h", ifc.rf_we, byp); end
    vectors++;
    if (ifc.hazard1 !== 1'b0) begin errors++; $display("FAIL b0_hazard1 got=%0h exp=0", ifc.hazard1); end
    if (byp) begin
      vectors++;
      if (ifc.rf_wa !== 5'd8 || ifc.rf_wd !== 32'h0000_00AA) begin
        errors++; $display("FAIL b0_byp_data got=%0d/%0h exp=8/aa", ifc.rf_wa, ifc.rf_wd);
      end
    end
    tick();
    ifc.b_valid = 1'b0;
    #1;
    vectors++;
    if (ifc.rf_we !== ~byp) begin errors++; $display("FAIL b1_rf_we got=%0h exp=%0h", ifc.rf_we, ~byp); end
    vectors++;
    if (ifc.hazard1 !== ~byp) begin errors++; $display("FAIL b1_hazard1 got=%0h exp=%0h", ifc.hazard1, ~byp); end
    if (!byp) begin
      vectors++;
      if (ifc.rf_wa !== 5'd8 || ifc.rf_wd !== 32'h0000_00AA) begin
        errors++; $display("FAIL b1_data got=%0d/%0h exp=8/aa", ifc.rf_wa, ifc.rf_wd);
      end
    end
    tick();
    vectors++;
    if (ifc.hazard1 !== 1'b0) begin errors++; $display("FAIL b2_hazard1 got=%0h exp=0", ifc.hazard1); end
    vectors++;
    if (ifc.rf_we !== 1'b0) begin errors++; $display("FAIL b2_rf_we got=%0h exp=0", ifc.rf_we); end
  endtask

  task automatic test_force_grant();
    idle();
    ifc.a_we = 1'b1; ifc.a_wa = 5'd1; ifc.a_wd = 32'h0000_0011;
    for (int i = 0; i < 4; i++) begin
      ifc.b_valid = 1'b1; ifc.b_wa = 5'(10 + i); ifc.b_wd = 32'(100 + i);
      #1;
      vectors++;
      if (ifc.b_ready !== 1'b1) begin errors++; $display("FAIL fg_b_ready[%0d] got=%0h exp=1", i, ifc.b_ready); end
      vectors++;
      if (ifc.a_stall !== 1'b0 || ifc.rf_wa !== 5'd1) begin
        errors++; $display("FAIL fg_a_win[%0d] got stall=%0h wa=%0d exp stall=0 wa=1", i, ifc.a_stall, ifc.rf_wa);
      end
      tick();
    end
    ifc.b_wa = 5'd14; ifc.b_wd = 32'd999;
    #1;
    vectors++;
    if (ifc.b_ready !== 1'b0) begin errors++; $display("FAIL fg_full_b_ready got=%0h exp=0", ifc.b_ready); end
    vectors++;
    if (ifc.a_stall !== 1'b1) begin errors++; $display("FAIL fg_forced_stall got=%0h exp=1", ifc.a_stall); end
    vectors++;
    if (ifc.rf_we !== 1'b1 || ifc.rf_wa !== 5'd10 || ifc.rf_wd !== 32'd100) begin
      errors++; $display("FAIL fg_forced_head got=%0h/%0d/%0d exp=1/10/100", ifc.rf_we, ifc.rf_wa, ifc.rf_wd);
    end
    tick();
    ifc.b_valid = 1'b0;
    #1;
    vectors++;
    if (ifc.a_stall !== 1'b0 || ifc.rf_wa !== 5'd1 || ifc.rf_wd !== 32'h0000_0011) begin
      errors++; $display("FAIL fg_retry got stall=%0h wa=%0d wd=%0h exp 0/1/11", ifc.a_stall, ifc.rf_wa, ifc.rf_wd);
    end
    tick();
    ifc.a_we = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      vectors++;
      if (ifc.rf_we !== 1'b1 || ifc.rf_wa !== 5'(10 + i) || ifc.rf_wd !== 32'(100 + i)) begin
        errors++; $display("FAIL fg_drain[%0d] got=%0h/%0d/%0d exp=1/%0d/%0d", i, ifc.rf_we, ifc.rf_wa, ifc.rf_wd, 10 + i, 100 + i);
      end
      tick();
    end
    vectors++;
    if (ifc.rf_we !== 1'b0) begin errors++; $display("FAIL fg_empty_rf_we got=%0h exp=0", ifc.rf_we); end
  endtask

  task automatic test_waw();
    idle();
    ifc.a_we = 1'b1; ifc.a_wa = 5'd2; ifc.a_wd = 32'h0000_0022;
    ifc.b_valid = 1'b1; ifc.b_wa = 5'd9; ifc.b_wd = 32'h0000_0055;
    #1;
    vectors++;
    if (ifc.rf_wa !== 5'd2 || ifc.a_stall !== 1'b0) begin
      errors++; $display("FAIL waw_a2 got wa=%0d stall=%0h exp 2/0", ifc.rf_wa, ifc.a_stall);
    end
    tick();
    ifc.b_valid = 1'b0;
    ifc.a_wa = 5'd9; ifc.a_wd = 32'h0000_0077;
    #1;
    vectors++;
    if (ifc.a_stall !== 1'b1) begin errors++; $display("FAIL waw_stall got=%0h exp=1", ifc.a_stall); end
    vectors++;
    if (ifc.rf_wa !== 5'd9 || ifc.rf_wd !== 32'h0000_0055) begin
      errors++; $display("FAIL waw_b_first got=%0d/%0h exp=9/55", ifc.rf_wa, ifc.rf_wd);
    end
    tick();
    vectors++;
    if (ifc.a_stall !== 1'b0 || ifc.rf_wa !== 5'd9 || ifc.rf_wd !== 32'h0000_0077) begin
      errors++; $display("FAIL waw_a_second got stall=%0h %0d/%0h exp 0/9/77", ifc.a_stall, ifc.rf_wa, ifc.rf_wd);
    end
    tick();
  endtask

  task automatic test_zero_addr();
    idle();
    ifc.a_we = 1'b1; ifc.a_wa = 5'd0; ifc.a_wd = 32'hDEAD_BEEF;
    ifc.b_valid = 1'b1; ifc.b_wa = 5'd0; ifc.b_wd = 32'h0BAD_F00D;
    #1;
    vectors++;
    if (ifc.rf_we !== 1'b0) begin errors++; $display("FAIL z_rf_we got=%0h exp=0", ifc.rf_we); end
    vectors++;
    if (ifc.b_ready !== 1'b1) begin errors++; $display("FAIL z_b_ready got=%0h exp=1", ifc.b_ready); end
    vectors++;
    if (ifc.hazard1 !== 1'b0) begin errors++; $display("FAIL z_hazard1 got=%0h exp=0", ifc.hazard1); end
    tick();
    idle();
    #1;
    vectors++;
    if (ifc.rf_we !== 1'b0) begin errors++; $display("FAIL z_next_rf_we got=%0h exp=0", ifc.rf_we); end
    vectors++;
    if (ifc.hazard1 !== 1'b0) begin errors++; $display("FAIL z_next_hazard1 got=%0h exp=0", ifc.hazard1); end
    tick();
  endtask

  task automatic test_reset_flush();
    idle();
    ifc.a_we = 1'b1; ifc.a_wa = 5'd3; ifc.a_wd = 32'h0000_0033;
    for (int i = 0; i < 3; i++) begin
      ifc.b_valid = 1'b1; ifc.b_wa = 5'(20 + i); ifc.b_wd = 32'(200 + i);
      tick();
    end
    idle();
    ifc.ra1 = 5'd20; ifc.ra2 = 5'd22;
    #1;
    vectors++;
    if (ifc.hazard1 !== 1'b1 || ifc.hazard2 !== 1'b1) begin
      errors++; $display("FAIL rf_pre_hazards got=%0h/%0h exp=1/1", ifc.hazard1, ifc.hazard2);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (ifc.rf_we !== 1'b0 || ifc.hazard1 !== 1'b0 || ifc.hazard2 !== 1'b0 || ifc.b_ready !== 1'b0) begin
      errors++; $display("FAIL rf_in_rst got we=%0h hz=%0h/%0h rdy=%0h exp 0/0/0/0", ifc.rf_we, ifc.hazard1, ifc.hazard2, ifc.b_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (ifc.hazard1 !== 1'b0 || ifc.hazard2 !== 1'b0) begin
      errors++; $display("FAIL rf_post_hazards got=%0h/%0h exp=0/0", ifc.hazard1, ifc.hazard2);
    end
    vectors++;
    if (ifc.rf_we !== 1'b0) begin errors++; $display("FAIL rf_post_rf_we got=%0h exp=0", ifc.rf_we); end
    vectors++;
    if (ifc.b_ready !== 1'b1) begin errors++; $display("FAIL rf_post_b_ready got=%0h exp=1", ifc.b_ready); end
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_a_write();
    test_b_drain();
    test_force_grant();
    test_waw();
    test_zero_addr();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
